hls_axis_stall_detector: RTL

- Generates the per-channel AXI-Stream block flags that the HLS deadlock monitors consume.
- Watches the TVALID/TREADY pair of NUM_CH stream channels between dataflow processes and counts consecutive stall cycles per channel.
- Asserts a channel's block flag once its stall persists THRESHOLD cycles.
- Queues one event per new block through a valid/ready report port for debug capture.

---
 rtl/hls_axis_stall_detector.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hls_axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags channels stalled for THRESHOLD
// consecutive cycles and queues one report event per new block.
module hls_axis_stall_detector #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned THRESHOLD = 1024,
    parameter int unsigned IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic [NUM_CH-1:0] block_dir,
    output logic              any_block,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_ch,
    output logic              evt_dir,
    output logic              evt_overflow,
    input  logic              clear_overflow
);

    localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] dir_q, dir_d;
    logic [NUM_CH-1:0] blk_d, bdir_d;
    logic [NUM_CH-1:0] rise_c;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pend_dir_q, pend_dir_d;
    logic [NUM_CH-1:0] lowest_c;
    logic [IDX_W-1:0]  sel_c;
    logic              load_c;
    logic              ovf_d;

    // Stall classification and saturating run-length counters.
    // A nonzero count means the previous cycle was a stall in direction dir_q.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        blk_d  = axis_block_sigs;
        bdir_d = block_dir;
        rise_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!enable) begin
                cnt_d[i]  = '0;
                blk_d[i]  = 1'b0;
                bdir_d[i] = 1'b0;
            end else if (ch_valid[i] == ch_ready[i]) begin
                cnt_d[i] = '0;
                blk_d[i] = 1'b0;
            end else if ((cnt_q[i] != '0) && (dir_q[i] == ch_valid[i])) begin
                if (cnt_q[i] != THR) begin
                    cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                    rise_c[i] = (cnt_q[i] == THR_M1);
                end
            end else begin
                cnt_d[i]  = CNT_W'(1);
                dir_d[i]  = ch_valid[i];
                blk_d[i]  = 1'b0;
                rise_c[i] = (THR == CNT_W'(1));
            end
            if (rise_c[i]) begin
                blk_d[i]  = 1'b1;
                bdir_d[i] = ch_valid[i];
            end
        end
    end

    // Pending bitmap, lowest-index arbitration and overflow tracking.
    always_comb begin
        lowest_c = pend_q & (~pend_q + NUM_CH'(1));
        load_c   = (!evt_valid || evt_ready) && (|pend_q);
        sel_c    = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_c = IDX_W'(i);
            end
        end
        pend_d     = (load_c ? (pend_q & ~lowest_c) : pend_q) | rise_c;
        pend_dir_d = (pend_dir_q & ~rise_c) | (ch_valid & rise_c);
        ovf_d      = (evt_overflow && !clear_overflow) || (|(rise_c & pend_q));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt_q[i] <= '0;
            end
            dir_q           <= '0;
            axis_block_sigs <= '0;
            block_dir       <= '0;
            any_block       <= 1'b0;
            pend_q          <= '0;
            pend_dir_q      <= '0;
            evt_valid       <= 1'b0;
            evt_ch          <= '0;
            evt_dir         <= 1'b0;
            evt_overflow    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            dir_q           <= dir_d;
            axis_block_sigs <= blk_d;
            block_dir       <= bdir_d;
            any_block       <= |blk_d;
            pend_q          <= pend_d;
            pend_dir_q      <= pend_dir_d;
            evt_overflow    <= ovf_d;
            if (load_c) begin
                evt_valid <= 1'b1;
                evt_ch    <= sel_c;
                evt_dir   <= |(lowest_c & pend_dir_q);
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
